updown_mod12: RTL and testbench
===============================

Name: updown_mod12

Overview:
- Synchronous modulo-N up/down counter, N = 12 by default, with a 4-bit count output.
- Counts up or down by one on every rising clock edge, selected by a direction input.
- Wraps at both ends of the range.
- Used as a general-purpose sequencing/cycle counter, e.g. for 12-state or hour-style sequences.

Parameters:
- MODULUS, 12, number of count states; Count cycles through 0..MODULUS-1. Legal range 2..2^WIDTH.
- WIDTH, 4, width of Count in bits.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset. Low forces Count to 0 immediately.
- UpOrDown  input  1  direction: 1 = count up, 0 = count down. Sampled at each rising Clk edge.
- Count  output  WIDTH  current count value, driven directly from the register.

Behaviour:
- Reset:
  - reset low asynchronously clears Count to 0, with no wait for a clock edge.
  - Count is held at 0 while reset is low.
  - Release is synchronous in effect: the first count change occurs on the first rising Clk edge after reset goes high.
- Every rising Clk edge with reset high updates Count. There is no enable; the counter is always running.
- Up (UpOrDown=1):
  - Count < MODULUS-1: Count <= Count+1.
  - Count == MODULUS-1 (11): Count <= 0.
- Down (UpOrDown=0):
  - Count > 0: Count <= Count-1.
  - Count == 0: Count <= MODULUS-1 (11).
- Direction change takes effect on the first edge at which the new UpOrDown value is sampled; there is no extra latency and no skipped state.
- UpOrDown unknown/X: treated as down (0), i.e. any value other than 1 counts down. Verification must not rely on X propagation.
- Illegal state recovery: Count >= MODULUS (12..15, reachable only through corruption):
  - Next edge forces Count to 0 regardless of direction.
  - Must not propagate into out-of-range sequences.
- Arithmetic is performed in WIDTH bits with explicit compare-to-bound wrap. Binary overflow must never be relied on, since MODULUS need not be a power of two.
- Count is a registered output with no combinational path from UpOrDown to Count.
- Reset asserted mid-count: Count goes to 0 immediately. After release, counting resumes from 0 in the current direction.

Optional Feature:
- Macro: UPDOWN_MOD12_TC_EN.
- Defined:
  - Adds output port Tc (1 bit).
  - Tc is combinational from the registered Count and UpOrDown.
  - Tc = 1 when (UpOrDown=1 and Count==MODULUS-1) or (UpOrDown=0 and Count==0), i.e. the next edge wraps.
  - Tc is 0 while reset is low.
  - Intended for cascading counters.
- Not defined:
  - Port Tc does not exist.
  - Counting behaviour is identical.

Test Plan:
- Reset: drive reset=0 with Count=7 mid-cycle -> Count=0 within the same timestep, before any Clk edge. Hold reset low for 3 edges -> Count stays 0.
- Up count and wrap: release reset, UpOrDown=1, run 14 edges -> Count 1,2,...,11,0,1,2.
- Down count and wrap: from reset, UpOrDown=0, run 13 edges -> Count 11,10,...,1,0,11.
- Direction reversal: count up to 5, then set UpOrDown=0 before the next edge -> Count 4,3. Switch back to 1 -> Count 4,5.
- Illegal state: force Count=14, release, one edge with UpOrDown=1 and another run with UpOrDown=0 -> Count=0 in both cases.
- With UPDOWN_MOD12_TC_EN:
  - Up direction: Tc=1 only while Count=11; Tc=0 elsewhere.
  - Down direction: Tc=1 only while Count=0.
  - Tc=0 during reset.

Source files
------------

// File: rtl/updown_mod12.sv
// Modulo-MODULUS up/down counter (default 12 states, 4-bit Count); optional Tc wrap flag under UPDOWN_MOD12_TC_EN.
// Latency: Count updates on every rising Clk edge; reset clears it asynchronously.
// Backpressure: none, the counter is always running and has no enable or stall input.
module updown_mod12 #(
    parameter int MODULUS = 12,
    parameter int WIDTH   = 4
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             UpOrDown,
`ifdef UPDOWN_MOD12_TC_EN
    output logic             Tc,
`endif
    output logic [WIDTH-1:0] Count
);

    // Top of the count range, held in WIDTH bits so every compare is width-matched.
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO    = '0;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nxt;
    logic             dir_up;
    logic             out_of_range;

    // Only a solid 1 counts up; X or 0 on the direction input falls into the down branch.
    assign dir_up = (UpOrDown == 1'b1);

    // A corrupted value above the top of the range is never a valid state.
    assign out_of_range = (count_q > MAX_CNT);

    // Next count: explicit compare-to-bound wrap in both directions, so a modulus
    // that is not a power of two never depends on binary overflow.
    always_comb begin
        count_nxt = count_q;
        if (out_of_range) begin
            count_nxt = ZERO;
        end else if (dir_up) begin
            if (count_q == MAX_CNT) begin
                count_nxt = ZERO;
            end else begin
                count_nxt = count_q + ONE;
            end
        end else begin
            if (count_q == ZERO) begin
                count_nxt = MAX_CNT;
            end else begin
                count_nxt = count_q - ONE;
            end
        end
    end

    // Count register: asynchronous clear, otherwise advance on every rising edge.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            count_q <= ZERO;
        end else begin
            count_q <= count_nxt;
        end
    end

    assign Count = count_q;

`ifdef UPDOWN_MOD12_TC_EN
    // Terminal count: high when the coming edge wraps in the current direction.
    // It is gated by reset because the cleared count would otherwise flag a down-wrap.
    always_comb begin
        Tc = 1'b0;
        if (reset == 1'b1) begin
            if (dir_up) begin
                Tc = (count_q == MAX_CNT);
            end else begin
                Tc = (count_q == ZERO);
            end
        end
    end
`endif

endmodule

// File: tb/tb_updown_mod12.sv
// Bench for updown_mod12: directed reset/wrap/reversal/illegal-state steps followed by
// randomized direction and reset traffic, all scored against an arithmetic modulo model.
// Outputs are sampled 1 time unit after each rising edge; inputs change right after sampling.
module tb_updown_mod12;

    localparam int M = 12;
    localparam int W = 4;

    logic         Clk;
    logic         reset;
    logic         UpOrDown;
    logic [W-1:0] Count;
`ifdef UPDOWN_MOD12_TC_EN
    logic         Tc;
`endif

    int tests;
    int fails;
    int model_cnt;

    updown_mod12 #(.MODULUS(M), .WIDTH(W)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .UpOrDown (UpOrDown),
`ifdef UPDOWN_MOD12_TC_EN
        .Tc       (Tc),
`endif
        .Count    (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference next state straight from the counting rules, using plain modulo arithmetic.
    function automatic int model_next(input int c, input logic up);
        if (c >= M) return 0;
        if (up === 1'b1) return (c + 1) % M;
        return (c + M - 1) % M;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare Count (and Tc when present) against the model for the current reset level.
    task automatic chk_state(input string tag);
        int obs;
        obs = (^Count === 1'bx) ? -1 : int'(Count);
        chk(tag, obs, model_cnt);
`ifdef UPDOWN_MOD12_TC_EN
        begin
            int exp_tc;
            int obs_tc;
            if (reset !== 1'b1) exp_tc = 0;
            else if (UpOrDown === 1'b1) exp_tc = (model_cnt == M - 1) ? 1 : 0;
            else exp_tc = (model_cnt == 0) ? 1 : 0;
            obs_tc = (Tc === 1'bx) ? -1 : int'(Tc);
            chk({tag, "_tc"}, obs_tc, exp_tc);
        end
`endif
    endtask

    // One rising edge: advance the model (unless in reset) and check just after the edge.
    task automatic step(input string tag);
        @(posedge Clk);
        if (reset === 1'b1) model_cnt = model_next(model_cnt, UpOrDown);
        else model_cnt = 0;
        #1;
        chk_state(tag);
    endtask

    // Asynchronous reset pulse between edges: Count must clear before any edge.
    task automatic reset_pulse(input string tag);
        reset = 1'b0;
        model_cnt = 0;
        #1;
        chk_state(tag);
        reset = 1'b1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        model_cnt = 0;
        reset     = 1'b1;
        UpOrDown  = 1'b1;

        // Async assert before any clock edge.
        #2 reset = 1'b0;
        #1 chk_state("rst_async_initial");

        // Held in reset across three edges, even counting up.
        for (int i = 0; i < 3; i++) step("rst_hold");

        // Release, count up to 7, then reset mid-cycle.
        reset = 1'b1;
        for (int i = 0; i < 7; i++) step("up_to_7");
        chk("count_is_7", int'(Count), 7);
        reset_pulse("rst_midcount");

        // Up count through the wrap: 1..11,0,1,2.
        UpOrDown = 1'b1;
        for (int i = 0; i < 14; i++) step("up_wrap");
        chk("up_wrap_end_2", int'(Count), 2);

        // Down count from reset through the wrap: 11..1,0,11.
        reset_pulse("rst_before_down");
        UpOrDown = 1'b0;
        for (int i = 0; i < 13; i++) step("down_wrap");
        chk("down_wrap_end_11", int'(Count), 11);

        // Direction reversal with no lost or repeated state.
        reset_pulse("rst_before_rev");
        UpOrDown = 1'b1;
        for (int i = 0; i < 5; i++) step("rev_up");
        UpOrDown = 1'b0;
        step("rev_down_4");
        step("rev_down_3");
        chk("rev_down_end_3", int'(Count), 3);
        UpOrDown = 1'b1;
        step("rev_up_4");
        step("rev_up_5");
        chk("rev_up_end_5", int'(Count), 5);

        // Illegal state recovery, counting up.
        force dut.count_q = 4'd14;
        #1 release dut.count_q;
        model_cnt = 14;
        UpOrDown = 1'b1;
        step("illegal_up");
        // Illegal state recovery, counting down.
        force dut.count_q = 4'd14;
        #1 release dut.count_q;
        model_cnt = 14;
        UpOrDown = 1'b0;
        step("illegal_down");
        step("illegal_down_after");

        // Randomized direction with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            UpOrDown = 1'($urandom % 2);
            if ($urandom_range(0, 39) == 0) reset_pulse("rnd_rst");
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
